// File: rtl/sbox_share_arbiter_if.sv
// Request/result bundle between the two SubBytes clients and the shared arbiter.
// master = requester side (round datapath + key expander), slave = arbiter.
interface sbox_share_arbiter_if;
   logic         in0_valid;
   logic         in0_ready;
   logic [127:0] in0_data;
   logic         in1_valid;
   logic         in1_ready;
   logic [31:0]  in1_data;
   logic         out0_valid;
   logic [127:0] out0_data;
   logic         out1_valid;
   logic [31:0]  out1_data;
   logic         busy;

   modport master (
      output in0_valid, in0_data, in1_valid, in1_data,
      input  in0_ready, in1_ready, out0_valid, out0_data, out1_valid, out1_data, busy
   );

   modport slave (
      input  in0_valid, in0_data, in1_valid, in1_data,
      output in0_ready, in1_ready, out0_valid, out0_data, out1_valid, out1_data, busy
   );
endinterface

// File: rtl/sbox_share_arbiter.sv
// Round-robin sharing of one pipelined 128-bit SubBytes between the round
// datapath (requester 0) and the key schedule SubWord (requester 1).
module sbox_share_arbiter #(
   parameter int unsigned SB_LAT = 1
) (
   input  logic               clk,
   input  logic               rst,
   sbox_share_arbiter_if.slave bus
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Inverse as a^254 (a^2 * a^4 * ... * a^128), which also maps 0 to 0.
   function automatic logic [7:0] sbox8(input logic [7:0] a);
      logic [7:0] t;
      logic [7:0] r;
      t = a;
      r = 8'h01;
      repeat (7) begin
         t = gf_mul(t, t);
         r = gf_mul(r, t);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub128(input logic [127:0] x);
      logic [127:0] r;
      r = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         r[8*i +: 8] = sbox8(x[8*i +: 8]);
      end
      return r;
   endfunction

   logic               w_gnt0;
   logic               w_gnt1;
   logic               w_xfer;
   logic               r_last;
   logic [127:0]       r_stage [SB_LAT];
   logic [127:0]       w_sb;
   logic [127:0]       w_sb_out;
   logic [SB_LAT-1:0]  r_tag_v;
   logic [SB_LAT-1:0]  r_tag_id;
   logic               r_out0_valid;
   logic               r_out1_valid;
   logic [127:0]       r_out0_data;
   logic [31:0]        r_out1_data;

   // r_last names the most recent winner; the other side wins a contention.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!rst) begin
         w_gnt0 = bus.in0_valid && (!bus.in1_valid || r_last);
         w_gnt1 = bus.in1_valid && (!bus.in0_valid || !r_last);
      end
   end

   assign w_xfer = w_gnt0 | w_gnt1;

   always_ff @(posedge clk) begin
      if (rst)         r_last <= 1'b1;
      else if (w_gnt0) r_last <= 1'b0;
      else if (w_gnt1) r_last <= 1'b1;
   end

   // Stage 0 is the mux register (held while idle); SubBytes logic sits after it.
   always_ff @(posedge clk) begin
      if (w_gnt0)      r_stage[0] <= bus.in0_data;
      else if (w_gnt1) r_stage[0] <= {96'h0, bus.in1_data};
      for (int unsigned k = 1; k < SB_LAT; k++) begin
         r_stage[k] <= (k == 1) ? w_sb : r_stage[k-1];
      end
   end

   assign w_sb     = sub128(r_stage[0]);
   assign w_sb_out = (SB_LAT == 1) ? w_sb : r_stage[SB_LAT-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tag_v  <= '0;
         r_tag_id <= '0;
      end else begin
         r_tag_v[0]  <= w_xfer;
         r_tag_id[0] <= w_gnt1;
         for (int unsigned k = 1; k < SB_LAT; k++) begin
            r_tag_v[k]  <= r_tag_v[k-1];
            r_tag_id[k] <= r_tag_id[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out0_valid <= 1'b0;
         r_out1_valid <= 1'b0;
         r_out0_data  <= '0;
         r_out1_data  <= '0;
      end else begin
         r_out0_valid <= r_tag_v[SB_LAT-1] && !r_tag_id[SB_LAT-1];
         r_out1_valid <= r_tag_v[SB_LAT-1] &&  r_tag_id[SB_LAT-1];
         if (r_tag_v[SB_LAT-1] && !r_tag_id[SB_LAT-1]) r_out0_data <= w_sb_out;
         if (r_tag_v[SB_LAT-1] &&  r_tag_id[SB_LAT-1]) r_out1_data <= w_sb_out[31:0];
      end
   end

   assign bus.in0_ready  = w_gnt0;
   assign bus.in1_ready  = w_gnt1;
   assign bus.out0_valid = r_out0_valid;
   assign bus.out1_valid = r_out1_valid;
   assign bus.out0_data  = r_out0_data;
   assign bus.out1_data  = r_out1_data;
   assign bus.busy       = (|r_tag_v) | r_out0_valid | r_out1_valid;

endmodule

// File: tb/tb_sbox_share_arbiter.sv
// Bench for sbox_share_arbiter: DUT A (SB_LAT=1) and DUT B (SB_LAT=3) against a
// queue-based reference model with a search-built S-box table.
module tb_sbox_share_arbiter;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;
   int   cyc;

   sbox_share_arbiter_if busA ();
   sbox_share_arbiter_if busB ();

   sbox_share_arbiter #(.SB_LAT(1)) dutA (.clk(clk), .rst(rst), .bus(busA));
   sbox_share_arbiter #(.SB_LAT(3)) dutB (.clk(clk), .rst(rst), .bus(busB));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int           dut;
      int           due;
      logic         id;
      logic [127:0] d;
   } ent_t;

   ent_t         pend [$];
   logic [7:0]   sbt [256];
   int           lat [2];
   logic         ev0 [2];
   logic         ev1 [2];
   logic [127:0] ed0 [2];
   logic [31:0]  ed1 [2];
   logic         mlast [2];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
      for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
      return p[7:0];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] s;
      logic [7:0] c;
      c = 8'h63;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         sbt[a] = s;
      end
   endtask

   function automatic logic [127:0] ref_sub(input logic [127:0] x);
      logic [127:0] r;
      for (int j = 0; j < 16; j++) r[8*j +: 8] = sbt[x[8*j +: 8]];
      return r;
   endfunction

   // {grant1, grant0}: alternate under contention, never grant during reset.
   function automatic logic [1:0] arb(input logic v0, input logic v1, input logic last, input logic r);
      if (r) return 2'b00;
      if (v0 && v1) return last ? 2'b01 : 2'b10;
      return {v1, v0};
   endfunction

   function automatic logic inflight(input int k);
      foreach (pend[i]) if (pend[i].dut == k) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [162:0] expv(input int k);
      return {ev0[k], ev1[k], inflight(k) | ev0[k] | ev1[k], ed0[k], ed1[k]};
   endfunction

   function automatic logic [162:0] actA();
      return {busA.out0_valid, busA.out1_valid, busA.busy, busA.out0_data, busA.out1_data};
   endfunction

   function automatic logic [162:0] actB();
      return {busB.out0_valid, busB.out1_valid, busB.busy, busB.out0_data, busB.out1_data};
   endfunction

   // Advance one clock edge and update the model with what the requesters offered.
   task automatic tick();
      logic [1:0]   g  [2];
      logic [127:0] d0 [2];
      logic [31:0]  d1 [2];
      logic         r;
      r = rst;
      g[0] = arb(busA.in0_valid, busA.in1_valid, mlast[0], r);
      g[1] = arb(busB.in0_valid, busB.in1_valid, mlast[1], r);
      d0[0] = busA.in0_data; d1[0] = busA.in1_data;
      d0[1] = busB.in0_data; d1[1] = busB.in1_data;
      @(posedge clk);
      cyc++;
      if (r) pend.delete();
      for (int k = 0; k < 2; k++) begin
         ev0[k] = 1'b0;
         ev1[k] = 1'b0;
         if (r) begin
            ed0[k] = '0; ed1[k] = '0; mlast[k] = 1'b1;
         end else begin
            for (int i = pend.size() - 1; i >= 0; i--) begin
               if (pend[i].dut == k && pend[i].due == cyc) begin
                  if (pend[i].id) begin ev1[k] = 1'b1; ed1[k] = pend[i].d[31:0]; end
                  else            begin ev0[k] = 1'b1; ed0[k] = pend[i].d;       end
                  pend.delete(i);
               end
            end
            if (g[k][0]) begin pend.push_back('{k, cyc + lat[k], 1'b0, ref_sub(d0[k])}); mlast[k] = 1'b0; end
            if (g[k][1]) begin pend.push_back('{k, cyc + lat[k], 1'b1, ref_sub({96'h0, d1[k]})}); mlast[k] = 1'b1; end
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      busA.in0_valid = 1'b0; busA.in1_valid = 1'b0;
      busB.in0_valid = 1'b0; busB.in1_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      busA.in0_valid = 1'b1; busA.in1_valid = 1'b1;
      busB.in0_valid = 1'b1; busB.in1_valid = 1'b1;
      #1;
      n_chk++;
      if ({busA.in1_ready, busA.in0_ready, busB.in1_ready, busB.in0_ready} !== 4'b0000)
         $display("FAIL reset_ready: got %b want 0000", {busA.in1_ready, busA.in0_ready, busB.in1_ready, busB.in0_ready});
      else n_pass++;
      tick(); tick();
      n_chk++;
      if (actA() !== 163'h0) $display("FAIL reset_outA: got %h want 0", actA()); else n_pass++;
      n_chk++;
      if (actB() !== 163'h0) $display("FAIL reset_outB: got %h want 0", actB()); else n_pass++;
      idle_inputs();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_in0();
      busA.in0_valid = 1'b1;
      busA.in0_data  = 128'h00102030405060708090a0b0c0d0e0f0;
      #1;
      n_chk++;
      if ({busA.in1_ready, busA.in0_ready} !== 2'b01) $display("FAIL in0_ready: got %b want 01", {busA.in1_ready, busA.in0_ready});
      else n_pass++;
      tick();
      busA.in0_valid = 1'b0;
      n_chk++;
      if (actA() !== expv(0)) $display("FAIL in0_wait: got %h want %h", actA(), expv(0)); else n_pass++;
      tick();
      n_chk++;
      if ({busA.out0_valid, busA.out1_valid, busA.out0_data} !== {2'b10, 128'h63cab7040953d051cd60e0e7ba70e18c})
         $display("FAIL in0_result: got %b%b %h want 10 63cab7040953d051cd60e0e7ba70e18c", busA.out0_valid, busA.out1_valid, busA.out0_data);
      else n_pass++;
      tick();
      n_chk++;
      if (actA() !== expv(0) || busA.out0_valid !== 1'b0) $display("FAIL in0_pulse_end: got %h want %h", actA(), expv(0)); else n_pass++;
   endtask

   task automatic test_single_in1();
      logic [127:0] keep;
      keep = busA.out0_data;
      busA.in1_valid = 1'b1;
      busA.in1_data  = 32'hc0d0e0f0;
      #1;
      n_chk++;
      if ({busA.in1_ready, busA.in0_ready} !== 2'b10) $display("FAIL in1_ready: got %b want 10", {busA.in1_ready, busA.in0_ready});
      else n_pass++;
      tick();
      busA.in1_valid = 1'b0;
      tick();
      n_chk++;
      if ({busA.out0_valid, busA.out1_valid, busA.out1_data, busA.out0_data} !== {2'b01, 32'hba70e18c, keep})
         $display("FAIL in1_result: got %b%b %h %h want 01 ba70e18c %h", busA.out0_valid, busA.out1_valid, busA.out1_data, busA.out0_data, keep);
      else n_pass++;
      tick();
      n_chk++;
      if (actA() !== expv(0)) $display("FAIL in1_after: got %h want %h", actA(), expv(0)); else n_pass++;
   endtask

   task automatic test_alternate();
      int p0;
      int p1;
      p0 = 0; p1 = 0;
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         busA.in0_valid = 1'b1; busA.in0_data = {$urandom, $urandom, $urandom, $urandom};
         busA.in1_valid = 1'b1; busA.in1_data = $urandom;
         #1;
         n_chk++;
         if ({busA.in1_ready, busA.in0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10))
            $display("FAIL alt_grant%0d: got %b want %b", i, {busA.in1_ready, busA.in0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
         else n_pass++;
         tick();
         p0 += int'(busA.out0_valid); p1 += int'(busA.out1_valid);
         n_chk++;
         if (actA() !== expv(0)) $display("FAIL alt_out%0d: got %h want %h", i, actA(), expv(0)); else n_pass++;
      end
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         tick();
         p0 += int'(busA.out0_valid); p1 += int'(busA.out1_valid);
         n_chk++;
         if (actA() !== expv(0)) $display("FAIL alt_drain%0d: got %h want %h", i, actA(), expv(0)); else n_pass++;
      end
      n_chk++;
      if (p0 !== 3 || p1 !== 3) $display("FAIL alt_count: got %0d/%0d want 3/3", p0, p1); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] want [4];
      logic [7:0] got  [$];
      logic [127:0] base;
      want = '{8'h8c, 8'ha1, 8'h89, 8'h0d};
      base = 128'h00102030405060708090a0b0c0d0e0f0;
      for (int i = 0; i < 6; i++) begin
         busA.in0_valid = (i < 4);
         busA.in0_data  = base | 128'(i);
         #1;
         tick();
         if (busA.out0_valid) got.push_back(busA.out0_data[7:0]);
         n_chk++;
         if (actA() !== expv(0)) $display("FAIL b2b_out%0d: got %h want %h", i, actA(), expv(0)); else n_pass++;
      end
      n_chk++;
      if (got.size() !== 4) $display("FAIL b2b_count: got %0d want 4", got.size());
      else if ({got[0], got[1], got[2], got[3]} !== {want[0], want[1], want[2], want[3]})
         $display("FAIL b2b_order: got %h%h%h%h want 8ca1890d", got[0], got[1], got[2], got[3]);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      busA.in1_valid = 1'b1; busA.in1_data = 32'h00102030;
      tick();
      busA.in1_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_chk++;
      if (actA() !== 163'h0) $display("FAIL rstmid_clear: got %h want 0", actA()); else n_pass++;
      tick();
      n_chk++;
      if (busA.out1_valid !== 1'b0 || busA.busy !== 1'b0) $display("FAIL rstmid_nopulse: got %b%b want 00", busA.out1_valid, busA.busy);
      else n_pass++;
      busA.in1_valid = 1'b1;
      tick();
      busA.in1_valid = 1'b0;
      tick();
      n_chk++;
      if ({busA.out1_valid, busA.out1_data} !== {1'b1, 32'h63cab704})
         $display("FAIL rstmid_next: got %b %h want 1 63cab704", busA.out1_valid, busA.out1_data);
      else n_pass++;
      tick();
   endtask

   task automatic test_lat3();
      int h0;
      int h1;
      int t0;
      int t1;
      int tlast;
      t0 = -1; t1 = -1; tlast = -1;
      busB.in0_valid = 1'b1; busB.in0_data = 128'h00102030405060708090a0b0c0d0e0f0;
      #1; h0 = cyc + 1;
      tick();
      busB.in0_valid = 1'b0;
      busB.in1_valid = 1'b1; busB.in1_data = 32'hc0d0e0f0;
      #1; h1 = cyc + 1;
      tick();
      busB.in1_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (busB.out0_valid) t0 = cyc;
         if (busB.out1_valid) begin t1 = cyc; tlast = cyc; end
         if (tlast >= 0 && cyc == tlast + 1) begin
            n_chk++;
            if (busB.busy !== 1'b0) $display("FAIL lat3_busy_drop: got %b want 0", busB.busy); else n_pass++;
         end
         n_chk++;
         if (actB() !== expv(1)) $display("FAIL lat3_out%0d: got %h want %h", i, actB(), expv(1)); else n_pass++;
         tick();
      end
      n_chk++;
      if (t0 - h0 !== 3 || t1 - h1 !== 3) $display("FAIL lat3_latency: got %0d/%0d want 3/3", t0 - h0, t1 - h1); else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         busA.in0_valid = ($urandom_range(0, 3) != 0); busA.in0_data = {$urandom, $urandom, $urandom, $urandom};
         busA.in1_valid = ($urandom_range(0, 2) == 0); busA.in1_data = $urandom;
         busB.in0_valid = ($urandom_range(0, 1) == 0); busB.in0_data = {$urandom, $urandom, $urandom, $urandom};
         busB.in1_valid = ($urandom_range(0, 1) == 0); busB.in1_data = $urandom;
         #1;
         n_chk++;
         if ({busA.in1_ready, busA.in0_ready, busB.in1_ready, busB.in0_ready} !==
             {arb(busA.in0_valid, busA.in1_valid, mlast[0], rst), arb(busB.in0_valid, busB.in1_valid, mlast[1], rst)})
            $display("FAIL rnd_ready%0d: got %b want %b", i, {busA.in1_ready, busA.in0_ready, busB.in1_ready, busB.in0_ready},
                     {arb(busA.in0_valid, busA.in1_valid, mlast[0], rst), arb(busB.in0_valid, busB.in1_valid, mlast[1], rst)});
         else n_pass++;
         tick();
         n_chk++;
         if (actA() !== expv(0) || actB() !== expv(1))
            $display("FAIL rnd_out%0d: got %h %h want %h %h", i, actA(), actB(), expv(0), expv(1));
         else n_pass++;
      end
      idle_inputs();
      for (int i = 0; i < 6; i++) tick();
      n_chk++;
      if ({busA.busy, busB.busy} !== 2'b00) $display("FAIL rnd_idle_busy: got %b want 00", {busA.busy, busB.busy}); else n_pass++;
   endtask

   initial begin
      n_chk = 0; n_pass = 0; cyc = 0;
      lat[0] = 1; lat[1] = 3;
      for (int k = 0; k < 2; k++) begin
         ev0[k] = 1'b0; ev1[k] = 1'b0; ed0[k] = '0; ed1[k] = '0; mlast[k] = 1'b1;
      end
      rst = 1'b1;
      idle_inputs();
      busA.in0_data = '0; busA.in1_data = '0; busB.in0_data = '0; busB.in1_data = '0;
      build_sbox();
      test_reset();
      test_single_in0();
      test_single_in1();
      test_alternate();
      test_back_to_back();
      test_reset_mid();
      test_lat3();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sbox_share_arbiter.md
Name: sbox_share_arbiter

Overview:
Shares one pipelined SubBytes datapath between two requesters: the round datapath (full 128-bit state) and the key schedule (32-bit SubWord). It grants at most one issue per clock with round-robin fairness, and tracks in-flight operations with a tag pipeline. Each result returns to the requester that issued it, as a registered single-cycle pulse. The block sits between the AES round controller / key expander and the SubBytes instance it owns internally.

Parameters:
SB_LAT, 1, register stages inside the SubBytes instance (input accepted at edge N appears on its output after edge N+SB_LAT-1); legal values 1..4.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in0_valid  input  1  round datapath request
in0_ready  output  1  grant to requester 0 (combinational)
in0_data  input  128  state to substitute
in1_valid  input  1  key-schedule request
in1_ready  output  1  grant to requester 1 (combinational)
in1_data  input  32  word to substitute
out0_valid  output  1  result pulse for requester 0
out0_data  output  128  SubBytes(in0_data)
out1_valid  output  1  result pulse for requester 1
out1_data  output  32  SubWord(in1_data)
busy  output  1  any operation in flight or in output stage

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Handshake: a transfer occurs on a rising edge where inX_valid and inX_ready are both 1. inX_ready is a combinational function of both valids and the priority pointer, with no dependence on the outputs. There is no output backpressure: requesters must accept result pulses.
- Arbitration:
  - Only in0_valid: in0_ready=1.
  - Only in1_valid: in1_ready=1.
  - Both valid: grant the requester not granted most recently.
  - Neither valid: both readys are 0.
  - Never both readys in the same cycle.
  - The 1-bit last_grant pointer updates only on a transfer.
- Datapath mux into SubBytes:
  - Grant 0: in0_data.
  - Grant 1: {96'h0, in1_data}.
  - Idle: hold the previous mux value; the tag is invalid.
- Tag pipeline: SB_LAT stages of {valid, id}. Stage 0 loads {transfer, granted id} at the transfer edge, then shifts every cycle. One issue per cycle, so full throughput.
- Output stage: registered. When the last tag stage is valid:
  - id 0: out0_data <= sb_out and out0_valid <= 1.
  - id 1: out1_data <= sb_out[31:0] and out1_valid <= 1.
  - The other valid is forced to 0.
  - Data registers hold their value between pulses. Valids are single-cycle pulses.
- Latency: handshake at edge N puts outX_valid high for exactly the cycle after edge N+SB_LAT (SB_LAT+1 cycles). Results return in issue order.
- busy = OR of all tag valids and both out valids.
- Reset values: out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, all tag valids=0, last_grant=1 (requester 0 wins the first contention), busy=0. in0_ready and in1_ready follow the valids in the same cycle that reset is asserted? No: both readys are forced to 0 while rst=1.
- Reset mid-operation: all in-flight tags are discarded and no result pulse appears afterwards. SubBytes internal data need not be cleared.
- Simultaneous events: a new issue and a result retirement in the same cycle are independent; both occur.
- Back-to-back grants to the same requester are allowed when the other requester is idle.

Test Plan:
1. Single in0 request, in0_data=128'h00102030405060708090a0b0c0d0e0f0, SB_LAT=1 -> out0_valid pulses for one cycle, 2 cycles after handshake, with out0_data=128'h63cab7040953d051cd60e0e7ba70e18c. out1_valid stays 0.
2. Single in1 request, in1_data=32'hc0d0e0f0 -> out1_valid pulse after SB_LAT+1 cycles with out1_data=32'hba70e18c. out0 registers unchanged.
3. Both valid continuously for 6 cycles after reset -> grants alternate 0,1,0,1,0,1. Results also alternate, each at the correct latency, one per cycle, with no drops.
4. Only in0 valid for 4 consecutive cycles with distinct data (…f0, …f1, …f2, …f3) -> 4 back-to-back out0 pulses in order. Last bytes are 8c, a1, 89, 0d.
5. Issue in1 (32'h00102030), then assert rst for one cycle before the result is due -> no out1_valid pulse, busy=0 and all outputs 0 after the reset edge. The next request after reset is served normally (32'h63cab704).
6. SB_LAT=3 with in0 and in1 issued on consecutive cycles -> results arrive 4 cycles after each handshake, in issue order, and busy deasserts the cycle after the last pulse.
